// File: rtl/pc_unit_if.sv
// Fetch-side bundle of the program-counter unit: control requests in, PC state out.
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_req;
    logic            halt_req;
    logic            resume_req;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fetch_valid;
    logic            flush;
    logic            misaligned;
    logic [XLEN-1:0] epc;
    logic            halted;

    modport master (
        output stall, redirect_valid, redirect_target, trap_req, halt_req, resume_req,
        input  pc, pc_plus4, fetch_valid, flush, misaligned, epc, halted
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, trap_req, halt_req, resume_req,
        output pc, pc_plus4, fetch_valid, flush, misaligned, epc, halted
    );
endinterface

// File: rtl/pc_unit.sv
// rv32i fetch program counter: sequential stepping, redirects, trap entry,
// stall and debug halt/resume, with EPC capture and one-cycle flush pulses.
module pc_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h100),
    parameter int              INC        = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic            flush_q;
    logic            mis_q;
    logic            tgt_ok;

    assign tgt_ok = (bus.redirect_target & ALIGN_MASK) == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    // Control flow outranks halt and stall; a bad target becomes a trap.
                    if (bus.trap_req || (bus.redirect_valid && !tgt_ok)) begin
                        pc_q    <= TRAP_VEC;
                        epc_q   <= pc_q;
                        flush_q <= 1'b1;
                        mis_q   <= !bus.trap_req;
                    end else if (bus.redirect_valid) begin
                        pc_q    <= bus.redirect_target;
                        flush_q <= 1'b1;
                    end else if (bus.halt_req) begin
                        state_q <= HALT;
                    end else if (!bus.stall) begin
                        pc_q <= pc_q + INC_W;
                    end
                end
                HALT: begin
                    // Pipeline is already drained here, so nothing in HALT raises flush.
                    if (bus.trap_req) begin
                        pc_q    <= TRAP_VEC;
                        epc_q   <= pc_q;
                        state_q <= RUN;
                    end else begin
                        if (bus.redirect_valid) begin
                            if (tgt_ok) pc_q  <= bus.redirect_target;
                            else        mis_q <= 1'b1;
                        end
                        if (bus.resume_req) state_q <= RUN;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + INC_W;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.halted      = (state_q == HALT);
    assign bus.flush       = flush_q;
    assign bus.misaligned  = mis_q;
    assign bus.epc         = epc_q;
endmodule
